mode_sched: RTL and testbench

MODE_SCHED -- requirements
Module: mode_sched

---
 rtl/mode_sched_pkg.sv | 27 ++
 rtl/mode_sched_rr_pick.sv | 43 ++++
 rtl/mode_sched.sv | 181 ++++++++++++++++++
 tb/tb_mode_sched.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/mode_sched_pkg.sv
// -----------------------------------------------------------------------------
// mode_sched_pkg
// Shared definitions for the mode scheduler: requester count, select width,
// the scheduler state type and a one-hot decode helper.
// No ports (package).
// -----------------------------------------------------------------------------
package mode_sched_pkg;

   localparam int NUM_REQ = 4;
   localparam int SEL_W   = 2;

   // IDLE: arbitrate, HOLD: grant owned, GAP: one dead cycle between owners
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      GAP  = 2'd2
   } state_e;

   // Decode a select value into a one-hot grant vector
   function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
      logic [NUM_REQ-1:0] v;
      v      = {NUM_REQ{1'b0}};
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/mode_sched_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Purely combinational round-robin picker. The search starts one position
// after last_owner and wraps, so the previous owner has lowest priority.
// Ports:
//   req        [NUM_REQ-1:0]  request vector, bit i asks for select value i
//   last_owner [SEL_W-1:0]    requester granted most recently
//   winner     [SEL_W-1:0]    first requester found in rotating order
//                             (last_owner when nothing is requested)
//   any_req                   at least one request bit is set
// -----------------------------------------------------------------------------
module rr_pick
   import mode_sched_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [SEL_W-1:0]   last_owner,
   output logic [SEL_W-1:0]   winner,
   output logic               any_req
);

   logic [SEL_W-1:0] idx_s;
   logic             found_s;

   // Rotating search: offsets 1..NUM_REQ from last_owner, first hit wins;
   // offset NUM_REQ wraps back onto last_owner itself.
   always_comb begin
      winner  = last_owner;
      found_s = 1'b0;
      idx_s   = last_owner;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx_s = last_owner + SEL_W'(k);
         if (!found_s && req[idx_s]) begin
            winner  = idx_s;
            found_s = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
   end

   assign any_req = |req;

endmodule

// File: rtl/mode_sched.sv
// -----------------------------------------------------------------------------
// mode_sched
// Round-robin scheduler for a 4:1 mode mux with a minimum grant dwell.
// A winner picked in IDLE owns the mux for at least HOLD_CYCLES cycles, then
// one GAP cycle with no grant separates owners before arbitration restarts.
//
// Parameters:
//   HOLD_CYCLES  minimum dwell in sys_clk cycles (1 .. 2^20-1)
//   CNT_W        dwell counter width, must hold HOLD_CYCLES-1
// Ports:
//   sys_clk    system clock, all state on rising edge
//   sys_rst    synchronous active-high reset
//   req        [3:0] request per requester
//   gnt        [3:0] registered one-hot grant, zero when nobody owns the mux
//   sel        [1:0] registered mux select, holds its value outside HOLD
//   sel_valid  high exactly when gnt is non-zero
//   busy       high whenever the scheduler is not in IDLE
// Build option:
//   MODE_SCHED_PREEMPT_EN  req[0] (obstacle stop) preempts any other owner and
//                          is granted first in the following arbitration.
// -----------------------------------------------------------------------------
module mode_sched
   import mode_sched_pkg::*;
#(
   parameter int unsigned HOLD_CYCLES = 1000,
   parameter int unsigned CNT_W       = 20
) (
   input  logic               sys_clk,
   input  logic               sys_rst,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] gnt,
   output logic [SEL_W-1:0]   sel,
   output logic               sel_valid,
   output logic               busy
);

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 32'd1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_e             state_q,      state_d;
   logic [CNT_W-1:0]   cnt_q,        cnt_d;
   logic [SEL_W-1:0]   last_owner_q, last_owner_d;
   logic [NUM_REQ-1:0] gnt_q,        gnt_d;
   logic [SEL_W-1:0]   sel_q,        sel_d;
   logic               sel_valid_q,  sel_valid_d;
   logic               busy_q,       busy_d;

   logic [SEL_W-1:0]   rr_ptr_s;
   logic [SEL_W-1:0]   winner_s;
   logic               any_req_s;
   logic               others_req_s;
   logic               release_s;
   logic               go_gap_s;

`ifdef MODE_SCHED_PREEMPT_EN
   logic               pre_q, pre_d;
   logic               preempt_s;

   // After a preemption the next search starts at requester 0
   assign rr_ptr_s  = pre_q ? {SEL_W{1'b1}} : last_owner_q;
   assign preempt_s = req[0] && (last_owner_q != {SEL_W{1'b0}});
`else
   assign rr_ptr_s  = last_owner_q;
`endif

   rr_pick u_rr_pick (
      .req        (req),
      .last_owner (rr_ptr_s),
      .winner     (winner_s),
      .any_req    (any_req_s)
   );

   // Dwell expiry hands over when the owner let go or someone else is waiting;
   // last_owner_q always names the current owner while in HOLD.
   assign others_req_s = |(req & ~onehot(last_owner_q));
   assign release_s    = (cnt_q == CNT_ZERO) && (!req[last_owner_q] || others_req_s);

`ifdef MODE_SCHED_PREEMPT_EN
   assign go_gap_s = preempt_s || release_s;
`else
   assign go_gap_s = release_s;
`endif

   // Next-state and registered-output decode
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      last_owner_d = last_owner_q;
      gnt_d        = gnt_q;
      sel_d        = sel_q;
      sel_valid_d  = sel_valid_q;
      busy_d       = busy_q;
`ifdef MODE_SCHED_PREEMPT_EN
      pre_d        = pre_q;
`endif
      case (state_q)
         IDLE: begin
            if (any_req_s) begin
               state_d      = HOLD;
               cnt_d        = CNT_LOAD;
               last_owner_d = winner_s;
               sel_d        = winner_s;
               gnt_d        = onehot(winner_s);
               sel_valid_d  = 1'b1;
               busy_d       = 1'b1;
`ifdef MODE_SCHED_PREEMPT_EN
               pre_d        = 1'b0;
`endif
            end else begin
               gnt_d       = {NUM_REQ{1'b0}};
               sel_valid_d = 1'b0;
               busy_d      = 1'b0;
            end
         end
         HOLD: begin
            if (go_gap_s) begin
               state_d     = GAP;
               cnt_d       = CNT_ZERO;
               gnt_d       = {NUM_REQ{1'b0}};
               sel_valid_d = 1'b0;
               busy_d      = 1'b1;
`ifdef MODE_SCHED_PREEMPT_EN
               pre_d       = preempt_s;
`endif
            end else if (cnt_q != CNT_ZERO) begin
               cnt_d = cnt_q - CNT_ONE;
            end else begin
               // Dwell expired, owner still asking and uncontested: keep it
               cnt_d = CNT_ZERO;
            end
         end
         GAP: begin
            state_d     = IDLE;
            gnt_d       = {NUM_REQ{1'b0}};
            sel_valid_d = 1'b0;
            busy_d      = 1'b0;
         end
         default: begin
            state_d     = IDLE;
            cnt_d       = CNT_ZERO;
            gnt_d       = {NUM_REQ{1'b0}};
            sel_valid_d = 1'b0;
            busy_d      = 1'b0;
         end
      endcase
   end

   // State, counter and output registers with synchronous reset
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q      <= IDLE;
         cnt_q        <= CNT_ZERO;
         last_owner_q <= {SEL_W{1'b1}};
         gnt_q        <= {NUM_REQ{1'b0}};
         sel_q        <= {SEL_W{1'b0}};
         sel_valid_q  <= 1'b0;
         busy_q       <= 1'b0;
`ifdef MODE_SCHED_PREEMPT_EN
         pre_q        <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         last_owner_q <= last_owner_d;
         gnt_q        <= gnt_d;
         sel_q        <= sel_d;
         sel_valid_q  <= sel_valid_d;
         busy_q       <= busy_d;
`ifdef MODE_SCHED_PREEMPT_EN
         pre_q        <= pre_d;
`endif
      end
   end

   assign gnt       = gnt_q;
   assign sel       = sel_q;
   assign sel_valid = sel_valid_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_mode_sched.sv
// -----------------------------------------------------------------------------
// tb_mode_sched
// Self-checking bench for mode_sched with HOLD_CYCLES=4. A behavioural model
// tracks who owns the mux, how long it has owned it and whether a gap cycle is
// pending; every cycle the DUT outputs are compared against it. Directed
// scenarios come first, then randomized request traffic with sporadic resets.
// -----------------------------------------------------------------------------
module tb_mode_sched;

   localparam int HOLD = 4;

   logic       sys_clk = 1'b0;
   logic       sys_rst = 1'b1;
   logic [3:0] req     = 4'b0000;
   logic [3:0] gnt;
   logic [1:0] sel;
   logic       sel_valid;
   logic       busy;

   int n_total = 0;
   int n_pass  = 0;

   // Model: owner (-1 = none), cycles owned so far (saturating), pending gap,
   // round-robin memory, select value and pending obstacle-stop priority.
   int m_owner = -1;
   int m_held  = 0;
   int m_last  = 3;
   int m_sel   = 0;
   bit m_gap   = 1'b0;
   bit m_pre   = 1'b0;

   mode_sched #(.HOLD_CYCLES(HOLD), .CNT_W(20)) dut (
      .sys_clk   (sys_clk),
      .sys_rst   (sys_rst),
      .req       (req),
      .gnt       (gnt),
      .sel       (sel),
      .sel_valid (sel_valid),
      .busy      (busy)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Apply one rising edge's worth of rules to the model
   task automatic model_edge(input logic [3:0] r, input logic rs);
      bit cut;
      bit others;
      bit found;
      int start;
      int w;
      cut = 1'b0; others = 1'b0; found = 1'b0; start = 0; w = 0;
      if (rs) begin
         m_owner = -1; m_held = 0; m_last = 3; m_sel = 0; m_gap = 1'b0; m_pre = 1'b0;
      end else if (m_owner >= 0) begin
         others = ((r & ~(4'b0001 << m_owner)) != 4'b0000);
`ifdef MODE_SCHED_PREEMPT_EN
         if (m_owner != 0 && r[0]) begin
            cut = 1'b1;
            m_pre = 1'b1;
         end
`endif
         if (m_held >= HOLD - 1 && (!r[m_owner] || others)) cut = 1'b1;
         if (cut) begin
            m_owner = -1;
            m_gap   = 1'b1;
         end else if (m_held < HOLD - 1) begin
            m_held++;
         end
      end else if (m_gap) begin
         m_gap = 1'b0;
      end else if (r != 4'b0000) begin
         start = m_pre ? 0 : (m_last + 1) % 4;
         for (int k = 0; k < 4; k++) begin
            if (!found && r[(start + k) % 4]) begin
               found = 1'b1;
               w = (start + k) % 4;
            end
         end
         m_owner = w; m_last = w; m_sel = w; m_held = 0; m_pre = 1'b0;
      end
   endtask

   // Drive one cycle, advance the model at the edge, compare just after it
   task automatic step(input logic [3:0] r, input logic rs, input string tag);
      logic [3:0] e_gnt;
      @(negedge sys_clk);
      req     = r;
      sys_rst = rs;
      @(posedge sys_clk);
      model_edge(r, rs);
      #1;
      e_gnt = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
      check({tag, ".gnt"},       32'(gnt),       32'(e_gnt));
      check({tag, ".sel"},       32'(sel),       32'(m_sel));
      check({tag, ".sel_valid"}, 32'(sel_valid), 32'(m_owner >= 0));
      check({tag, ".busy"},      32'(busy),      32'(m_owner >= 0 || m_gap));
   endtask

   task automatic do_reset(input logic [3:0] r);
      step(r, 1'b1, "reset");
      step(r, 1'b1, "reset");
   endtask

   initial begin
      logic [3:0] r;
      int         len;
      logic       rs;

      // Reset with all requests high, then first grant must go to requester 0
      do_reset(4'b1111);
      check("reset_gnt", 32'(gnt), 32'h0);
      step(4'b1111, 1'b0, "first");
      check("first_grant", 32'(gnt), 32'h1);

      // Fairness under constant full load
      for (int i = 0; i < 30; i++) step(4'b1111, 1'b0, "fair");

      // Single requester held, then dropped
      do_reset(4'b0000);
      step(4'b0100, 1'b0, "single");
      check("single_sel", 32'(sel), 32'h2);
      for (int i = 0; i < 6; i++) step(4'b0100, 1'b0, "single");
      check("single_held", 32'(gnt), 32'h4);
      step(4'b0000, 1'b0, "single_gap");
      step(4'b0000, 1'b0, "single_idle");
      check("single_sel_keep", 32'(sel), 32'h2);
      check("single_idle_gnt", 32'(gnt), 32'h0);

      // Early drop: one-cycle request still gets the full dwell
      do_reset(4'b0000);
      step(4'b0010, 1'b0, "early");
      for (int i = 0; i < 3; i++) step(4'b0000, 1'b0, "early");
      check("early_held", 32'(gnt), 32'h2);
      step(4'b0000, 1'b0, "early_gap");
      check("early_gap_gnt", 32'(gnt), 32'h0);
      step(4'b0000, 1'b0, "early");

      // Obstacle stop arriving in the second cycle of requester 2's grant
      do_reset(4'b0000);
      step(4'b0100, 1'b0, "pre");
      step(4'b0100, 1'b0, "pre");
      step(4'b0101, 1'b0, "pre");
`ifdef MODE_SCHED_PREEMPT_EN
      check("pre_cut", 32'(gnt), 32'h0);
`else
      check("pre_ignored", 32'(gnt), 32'h4);
`endif
      for (int i = 0; i < 6; i++) step(4'b0001, 1'b0, "pre");
      check("pre_then_0", 32'(gnt), 32'h1);

      // Reset in the middle of requester 3's grant
      do_reset(4'b0000);
      step(4'b1000, 1'b0, "midrst");
      step(4'b1000, 1'b0, "midrst");
      step(4'b1111, 1'b1, "midrst_rst");
      check("midrst_gnt", 32'(gnt), 32'h0);
      step(4'b1111, 1'b0, "midrst");
      check("midrst_next", 32'(gnt), 32'h1);

      // Randomized traffic: request patterns held for 1..6 cycles
      for (int i = 0; i < 300; i++) begin
         r = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 3) == 0) r = 4'b0000;
         len = $urandom_range(1, 6);
         rs  = ($urandom_range(0, 99) == 0);
         for (int j = 0; j < len; j++) begin
            step(r, rs && (j == 0), "rand");
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
